// File: rtl/neuron_lut_loader.sv
// Runtime-loadable truth-table neuron: streams a full LUT in over a valid/ready port, then
// serves registered 1-cycle lookups. Define LUT_LOAD_CHECKSUM_EN to add an XOR load checksum.
module neuron_lut_loader #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned LOAD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LOAD_W-1:0]   cfg_data,
    input  logic                cfg_last,
`ifdef LUT_LOAD_CHECKSUM_EN
    input  logic [LOAD_W-1:0]   cfg_chk,
`endif
    output logic                load_done,
    output logic                load_err,
    output logic                table_ok,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int unsigned Depth = 2 ** IN_BITS;
    localparam int unsigned TblW  = Depth * OUT_BITS;
    localparam int unsigned Epb   = LOAD_W / OUT_BITS;
    localparam int unsigned Beats = Depth / Epb;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    if ((LOAD_W % OUT_BITS) != 0 || (TblW % LOAD_W) != 0) begin : g_param_err
        $error("neuron_lut_loader: LOAD_W must be a multiple of OUT_BITS and divide the table");
    end

    typedef enum logic [1:0] {StEmpty, StLoad, StReady} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [TblW-1:0]     tbl_q, tbl_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                beat_acc, last_beat, chk_ok, lookup_en;
    logic [31:0]         beat_base, rd_base;

    assign beat_base = 32'(cnt_q) * LOAD_W;
    assign rd_base   = 32'(in_data) * OUT_BITS;

    // cfg_start pre-empts everything in the cycle it is seen: no beat, no lookup, no table_ok.
    assign cfg_ready = (state_q == StLoad) && !cfg_start;
    assign table_ok  = (state_q == StReady) && !cfg_start;
    assign lookup_en = in_valid && table_ok;
    assign beat_acc  = cfg_valid && cfg_ready;
    assign last_beat = (cnt_q == CntW'(Beats - 1));

`ifdef LUT_LOAD_CHECKSUM_EN
    logic [LOAD_W-1:0] chk_q, chk_d;

    assign chk_ok = ((chk_q ^ cfg_data) == cfg_chk);

    always_comb begin
        chk_d = chk_q;
        if (cfg_start) begin
            chk_d = '0;
        end else if (beat_acc) begin
            chk_d = chk_q ^ cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (cfg_start) begin
            state_d = StLoad;
            cnt_d   = '0;
        end else if (beat_acc) begin
            tbl_d[beat_base +: LOAD_W] = cfg_data;
            if (cfg_last && last_beat && chk_ok) begin
                state_d = StReady;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else if (cfg_last || last_beat) begin
                state_d = StEmpty;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = lookup_en;
        out_data_d  = out_data_q;
        if (lookup_en) begin
            out_data_d = tbl_q[rd_base +: OUT_BITS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            cnt_q       <= '0;
            tbl_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tbl_q       <= tbl_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign load_done = done_q;
    assign load_err  = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Scoreboard bench for neuron_lut_loader: lookups push expected entries, a negedge monitor
// pops and compares them against out_valid/out_data every cycle.
module tb_neuron_lut_loader;

    localparam int unsigned InBits  = 8;
    localparam int unsigned OutBits = 1;
    localparam int unsigned LoadW   = 8;
    localparam int unsigned Depth   = 256;
    localparam int unsigned Beats   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
    logic              cfg_ready;
    logic [LoadW-1:0]  cfg_data = '0;
    logic [LoadW-1:0]  cfg_chk = '0;
    logic              load_done, load_err, table_ok;
    logic              in_valid = 1'b0;
    logic [InBits-1:0] in_data = '0;
    logic              out_valid;
    logic [OutBits-1:0] out_data;

    neuron_lut_loader #(
        .IN_BITS (InBits),
        .OUT_BITS(OutBits),
        .LOAD_W  (LoadW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .cfg_last (cfg_last),
`ifdef LUT_LOAD_CHECKSUM_EN
        .cfg_chk  (cfg_chk),
`endif
        .load_done(load_done),
        .load_err (load_err),
        .table_ok (table_ok),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic        data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        mon_v;
    logic        last_exp = 1'b0;
    logic        model_tbl[Depth];
    int unsigned cyc = 0;
    int          checks = 0, errors = 0;
    int          done_cnt = 0, err_cnt = 0;
    logic [7:0]  run_xor = '0;
    logic        chk_force_en = 1'b0;
    logic [7:0]  chk_force = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: exact 1-cycle latency, out_data must hold between results.
    always @(negedge clk) begin
        if (rst) begin
            last_exp = 1'b0;
        end else begin
            if (load_done === 1'b1) done_cnt++;
            if (load_err === 1'b1) err_cnt++;
            mon_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            checks++;
            if (out_valid !== mon_v) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got %b expected %b", cyc, out_valid, mon_v);
            end
            if (mon_v) begin
                mon_e = exp_q.pop_front();
                last_exp = mon_e.data;
            end
            checks++;
            if (out_data !== last_exp) begin
                errors++;
                $display("FAIL out_data cyc=%0d got %b expected %b", cyc, out_data, last_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < Depth; i++) model_tbl[i] = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        run_xor = '0;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input int k);
        logic r;
        logic ok;
        ok = 1'b0;
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        cfg_chk = chk_force_en ? chk_force : (run_xor ^ d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = cfg_ready;
            tick();
            if (r === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake beat=%0d got no cfg_ready expected accept", k);
        end else begin
            run_xor = run_xor ^ d;
            if (k < Beats) for (int j = 0; j < 8; j++) model_tbl[k*8+j] = d[j];
        end
    endtask

    task automatic do_lookup(input logic [7:0] addr, input logic acc);
        exp_t e;
        in_valid = 1'b1;
        in_data = addr;
        if (acc) begin
            e.due = cyc + 1;
            e.data = model_tbl[addr];
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic lookup_all();
        for (int a = 0; a < Depth; a++) do_lookup(8'(a), 1'b1);
        drain();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) do_lookup(8'h40, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checks += 5;
        if (table_ok !== 1'b0) begin errors++; $display("FAIL rst_table_ok got %b expected 0", table_ok); end
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_cfg_ready got %b expected 0", cfg_ready); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done got %b expected 0", load_done); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL rst_load_err got %b expected 0", load_err); end
        if (out_data !== 1'b0) begin errors++; $display("FAIL rst_out_data got %b expected 0", out_data); end
        tick();
    endtask

    task automatic test_load_cc();
        int d0;
        d0 = done_cnt;
        start_pulse();
        for (int k = 0; k < Beats; k++) send_beat(8'hCC, k == Beats - 1, k);
        @(negedge clk);
        checks += 2;
        if (load_done !== 1'b1) begin errors++; $display("FAIL cc_load_done got %b expected 1", load_done); end
        if (table_ok !== 1'b1) begin errors++; $display("FAIL cc_table_ok got %b expected 1", table_ok); end
        tick();
        do_lookup(8'h02, 1'b1);
        do_lookup(8'h01, 1'b1);
        drain();
        checks += 2;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL cc_done_pulses got %0d expected 1", done_cnt - d0); end
        if (model_tbl[2] !== 1'b1 || model_tbl[1] !== 1'b0) begin
            errors++; $display("FAIL cc_pattern got %b%b expected 10", model_tbl[2], model_tbl[1]);
        end
        lookup_all();
    endtask

    task automatic test_restart();
        int e0;
        do_lookup(8'h03, 1'b1);
        cfg_start = 1'b1; in_valid = 1'b1; in_data = 8'h02; run_xor = '0;
        @(negedge clk);
        checks++;
        if (table_ok !== 1'b0) begin errors++; $display("FAIL restart_table_ok got %b expected 0", table_ok); end
        tick();
        cfg_start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 10; k++) send_beat(8'hFF, 1'b0, k);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h00; run_xor = '0;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        e0 = err_cnt;
        for (int k = 0; k < 5; k++) send_beat(8'h5A, k == 4, k);
        @(negedge clk);
        checks += 3;
        if (load_err !== 1'b1) begin errors++; $display("FAIL early_last_err got %b expected 1", load_err); end
        if (table_ok !== 1'b0) begin errors++; $display("FAIL early_last_table_ok got %b expected 0", table_ok); end
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL early_last_ready got %b expected 0", cfg_ready); end
        tick();
        do_lookup(8'h10, 1'b0);
        drain();
        checks++;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL early_last_pulses got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_start_drop_full();
        int d0;
        start_pulse();
        for (int k = 0; k < 3; k++) send_beat(8'h77, 1'b0, 99);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hEE; run_xor = '0;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < Beats; k++) send_beat(8'($urandom), k == Beats - 1, k);
        repeat (2) tick();
        checks += 2;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL drop_done got %0d expected 1", done_cnt - d0); end
        if (table_ok !== 1'b1) begin errors++; $display("FAIL drop_table_ok got %b expected 1", table_ok); end
        lookup_all();
    endtask

    task automatic test_missing_last();
        int d0;
        d0 = done_cnt;
        start_pulse();
        for (int k = 0; k < Beats; k++) send_beat(8'hA5, 1'b0, k);
        @(negedge clk);
        checks += 2;
        if (load_err !== 1'b1) begin errors++; $display("FAIL nolast_err got %b expected 1", load_err); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL nolast_done got %b expected 0", load_done); end
        tick();
        @(negedge clk);
        checks += 3;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL nolast_ready got %b expected 0", cfg_ready); end
        if (table_ok !== 1'b0) begin errors++; $display("FAIL nolast_table_ok got %b expected 0", table_ok); end
        if (done_cnt != d0) begin errors++; $display("FAIL nolast_done_cnt got %0d expected %0d", done_cnt, d0); end
        tick();
    endtask

    task automatic test_toggle_valid();
        int d0;
        d0 = done_cnt;
        start_pulse();
        for (int k = 0; k < Beats; k++) begin
            send_beat(8'($urandom), k == Beats - 1, k);
            @(negedge clk);
            if (k < Beats - 1 && $urandom_range(1) == 1) begin
                checks++;
                if (cfg_ready !== 1'b1) begin
                    errors++; $display("FAIL toggle_ready beat=%0d got %b expected 1", k, cfg_ready);
                end
            end
            tick();
        end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL toggle_done got %0d expected 1", done_cnt - d0); end
        lookup_all();
    endtask

    task automatic test_midload_reset();
        int d0, e0;
        start_pulse();
        for (int k = 0; k < 5; k++) send_beat(8'h3C, 1'b0, k);
        d0 = done_cnt; e0 = err_cnt;
        do_reset();
        @(negedge clk);
        checks += 3;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b expected 0", cfg_ready); end
        if (table_ok !== 1'b0) begin errors++; $display("FAIL midrst_table_ok got %b expected 0", table_ok); end
        if (done_cnt != d0 || err_cnt != e0) begin
            errors++; $display("FAIL midrst_pulses got %0d/%0d expected %0d/%0d", done_cnt, err_cnt, d0, e0);
        end
        tick();
    endtask

`ifdef LUT_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        int d0, e0;
        chk_force_en = 1'b1;
        chk_force = 8'h20;
        d0 = done_cnt;
        start_pulse();
        for (int k = 0; k < Beats; k++) send_beat(8'(k + 1), k == Beats - 1, k);
        repeat (2) tick();
        checks += 2;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL chk_good_done got %0d expected 1", done_cnt - d0); end
        if (table_ok !== 1'b1) begin errors++; $display("FAIL chk_good_table_ok got %b expected 1", table_ok); end
        chk_force = 8'h21;
        d0 = done_cnt; e0 = err_cnt;
        start_pulse();
        for (int k = 0; k < Beats; k++) send_beat(8'(k + 1), k == Beats - 1, k);
        repeat (2) tick();
        checks += 3;
        if (err_cnt - e0 != 1) begin errors++; $display("FAIL chk_bad_err got %0d expected 1", err_cnt - e0); end
        if (done_cnt != d0) begin errors++; $display("FAIL chk_bad_done got %0d expected %0d", done_cnt, d0); end
        if (table_ok !== 1'b0) begin errors++; $display("FAIL chk_bad_table_ok got %b expected 0", table_ok); end
        chk_force_en = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_cc();
        test_restart();
        test_start_drop_full();
        test_missing_last();
        test_toggle_valid();
        test_midload_reset();
`ifdef LUT_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
